// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: shared memory-stage definitions for the store/load path.
//   XLEN           - datapath width.
//   IO_BIT_DEFAULT - default address bit that selects IO space.
//   io_req_t       - one queued IO write: {addr, data}.
package riscv_mem_pkg;

  localparam int XLEN           = 32;
  localparam int IO_BIT_DEFAULT = 10;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
  } io_req_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count and head-of-queue view.
// Ports:
//   clk, rst   - clock, synchronous active-high reset (empties the queue)
//   push, din  - write request and data; ignored while full
//   pop        - read request; ignored while empty
//   full/empty - derived from the registered count
//   count      - current occupancy, 0..DEPTH
//   head       - oldest entry (undefined contents while empty)
module sync_fifo #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // DEPTH is a power of two, so the pointers wrap naturally at AW bits.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (!do_push && do_pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; stale entries are never visible because
  // empty is derived from the reset count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/mmio_store_unit.sv
// mmio_store_unit: MEM-stage store router. Stores with memAddr[IO_BIT] clear
// write data memory directly; stores with it set are queued and drained to
// the IO bus over a valid/ready handshake.
// Ports:
//   clk, rst                     - clock, synchronous active-high reset
//   memWrite, memRead            - MEM-stage store / load request
//   memAddr, memWdata            - MEM-stage address and store data
//   dm_we, dm_addr, dm_wdata     - data-memory write port
//   io_valid, io_ready           - IO write handshake
//   io_addr, io_dout             - IO write head entry (0 when queue empty)
//   stall                        - freeze IF..MEM, bubble into MEM/WB
//   count                        - IO queue occupancy
// Build option: define MMIO_LOAD_FENCE_EN to hold IO loads until every
// queued IO store has drained.
module mmio_store_unit
  import riscv_mem_pkg::*;
#(
  parameter  int DEPTH  = 4,
  parameter  int IO_BIT = IO_BIT_DEFAULT,
  localparam int CW     = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            memWrite,
  input  logic            memRead,
  input  logic [XLEN-1:0] memAddr,
  input  logic [XLEN-1:0] memWdata,
  output logic            dm_we,
  output logic [XLEN-1:0] dm_addr,
  output logic [XLEN-1:0] dm_wdata,
  output logic            io_valid,
  input  logic            io_ready,
  output logic [XLEN-1:0] io_addr,
  output logic [XLEN-1:0] io_dout,
  output logic            stall,
  output logic [CW-1:0]   count
);

  logic    is_io;
  logic    q_full, q_empty;
  logic    q_push, q_pop;
  logic    fence_stall;
  io_req_t push_req, head_req;

  assign is_io = memAddr[IO_BIT];

  assign dm_we    = memWrite & ~is_io;
  assign dm_addr  = memAddr;
  assign dm_wdata = memWdata;

  // A blocked store is simply retried: the frozen pipeline re-presents it.
  assign q_push   = memWrite & is_io & ~q_full;
  assign q_pop    = io_valid & io_ready;
  assign push_req = '{addr: memAddr, data: memWdata};

  sync_fifo #(
    .WIDTH ($bits(io_req_t)),
    .DEPTH (DEPTH)
  ) u_io_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (q_push),
    .din   (push_req),
    .pop   (q_pop),
    .full  (q_full),
    .empty (q_empty),
    .count (count),
    .head  (head_req)
  );

  assign io_valid = ~q_empty;
  assign io_addr  = q_empty ? '0 : head_req.addr;
  assign io_dout  = q_empty ? '0 : head_req.data;

`ifdef MMIO_LOAD_FENCE_EN
  // Device registers see loads in program order after earlier stores.
  assign fence_stall = memRead & is_io & ~q_empty;
`else
  logic fence_unused;
  assign fence_unused = memRead;
  assign fence_stall  = 1'b0;
`endif

  // q_full is registered, so io_ready never reaches stall combinationally.
  assign stall = (memWrite & is_io & q_full) | fence_stall;

endmodule

// File: tb/tb_mmio_store_unit.sv
module tb_mmio_store_unit;

  localparam int DEPTH  = 4;
  localparam int IO_BIT = 10;
`ifdef MMIO_LOAD_FENCE_EN
  localparam bit FENCE = 1'b1;
`else
  localparam bit FENCE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        memWrite, memRead, io_ready;
  logic [31:0] memAddr, memWdata;
  logic        dm_we, io_valid, stall;
  logic [31:0] dm_addr, dm_wdata, io_addr, io_dout;
  logic [2:0]  count;

  mmio_store_unit #(.DEPTH(DEPTH), .IO_BIT(IO_BIT)) dut (
    .clk      (clk),
    .rst      (rst),
    .memWrite (memWrite),
    .memRead  (memRead),
    .memAddr  (memAddr),
    .memWdata (memWdata),
    .dm_we    (dm_we),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .io_valid (io_valid),
    .io_ready (io_ready),
    .io_addr  (io_addr),
    .io_dout  (io_dout),
    .stall    (stall),
    .count    (count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  ent_t mq[$];     // reference queue contents (what the device should hold)
  ent_t exp_q[$];  // scoreboard: transfers the IO bus should see, in order

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every accepted IO transfer must match the oldest expected store.
  always @(negedge clk) begin : monitor
    ent_t e;
    if (rst === 1'b0 && io_valid === 1'b1 && io_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL xfer_unexpected actual=%h required=none", io_addr);
      end else begin
        e = exp_q.pop_front();
        chk("xfer_addr", io_addr, e.a);
        chk("xfer_data", io_dout, e.d);
      end
    end
  end

  // One pipeline cycle: drive, check mid-cycle, then advance the model at the edge.
  task automatic step(input logic w, input logic r, input logic [31:0] a,
                      input logic [31:0] d, input logic rdy, input logic rs);
    int cnt;
    bit io, exp_stall, push, pop;
    memWrite = w; memRead = r; memAddr = a; memWdata = d; io_ready = rdy; rst = rs;
    cnt = mq.size();
    io  = a[IO_BIT];
    exp_stall = (w && io && cnt == DEPTH) || (FENCE && r && io && cnt != 0);
    @(negedge clk);
    chk("dm_we", {31'b0, dm_we}, {31'b0, w && !io});
    chk("dm_addr", dm_addr, a);
    chk("dm_wdata", dm_wdata, d);
    chk("stall", {31'b0, stall}, {31'b0, exp_stall});
    chk("count", {29'b0, count}, cnt);
    chk("io_valid", {31'b0, io_valid}, {31'b0, cnt != 0});
    if (cnt == 0) begin
      chk("io_addr_empty", io_addr, 32'h0);
      chk("io_dout_empty", io_dout, 32'h0);
    end else begin
      chk("io_addr_head", io_addr, mq[0].a);
      chk("io_dout_head", io_dout, mq[0].d);
    end
    @(posedge clk);
    if (rs) begin
      mq.delete();
      exp_q.delete();
    end else begin
      pop  = (cnt != 0) && rdy;
      push = w && io && (cnt < DEPTH);
      if (pop) void'(mq.pop_front());
      if (push) begin
        mq.push_back('{a, d});
        exp_q.push_back('{a, d});
      end
    end
    #1;
  endtask

  initial begin
    logic        w, r, rdy, rs, hold, stall_now;
    logic [31:0] a, d;
    int          op;

    rst = 1'b1; memWrite = 1'b0; memRead = 1'b0; io_ready = 1'b0;
    memAddr = '0; memWdata = '0;
    repeat (2) @(posedge clk);
    #1;

    // reset state, then a plain memory store
    step(0, 0, 32'h0, 32'h0, 0, 0);
    step(1, 0, 32'h0000_0010, 32'hDEAD_BEEF, 0, 0);

    // single IO store held with io_ready low, then one transfer
    step(1, 0, 32'h0000_0404, 32'h12, 0, 0);
    repeat (3) step(0, 0, 32'h0, 32'h0, 0, 0);
    step(0, 0, 32'h0, 32'h0, 1, 0);
    step(0, 0, 32'h0, 32'h0, 0, 0);

    // fill, blocked fifth store retried, drain in order with wrap
    for (int i = 1; i <= 4; i++) step(1, 0, 32'h400 + 32'(i * 4), 32'(i), 0, 0);
    step(1, 0, 32'h414, 32'h5, 0, 0);
    step(1, 0, 32'h414, 32'h5, 1, 0);
    step(1, 0, 32'h414, 32'h5, 1, 0);
    repeat (5) step(0, 0, 32'h0, 32'h0, 1, 0);

    // concurrent push/pop at occupancy 2
    step(1, 0, 32'h420, 32'hA0, 0, 0);
    step(1, 0, 32'h424, 32'hA1, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 32'h500 + 32'(i * 4), 32'hB0 + 32'(i), 1, 0);
    repeat (3) step(0, 0, 32'h0, 32'h0, 1, 0);

    // IO load behind two pending IO stores
    step(1, 0, 32'h430, 32'hC0, 0, 0);
    step(1, 0, 32'h434, 32'hC1, 0, 0);
    repeat (2) step(0, 1, 32'h400, 32'h0, 0, 0);
    repeat (3) step(0, 1, 32'h400, 32'h0, 1, 0);

    // reset mid-handshake, then a fresh single IO store
    for (int i = 0; i < 3; i++) step(1, 0, 32'h440 + 32'(i * 4), 32'hD0 + 32'(i), 0, 0);
    step(0, 0, 32'h0, 32'h0, 1, 1);
    step(0, 0, 32'h0, 32'h0, 0, 0);
    step(1, 0, 32'h0000_0404, 32'h12, 0, 0);
    repeat (3) step(0, 0, 32'h0, 32'h0, 0, 0);
    step(0, 0, 32'h0, 32'h0, 1, 0);
    step(0, 0, 32'h0, 32'h0, 0, 0);

    // randomized traffic; a stalled request is held, as the pipeline would
    hold = 1'b0; w = 1'b0; r = 1'b0; a = '0; d = '0;
    for (int n = 0; n < 3000; n++) begin
      if (!hold) begin
        op = $urandom_range(0, 3);
        a  = $urandom;
        a[IO_BIT] = ($urandom_range(0, 2) != 0);
        d  = $urandom;
        w  = (op == 1 || op == 2);
        r  = (op == 3);
      end
      rdy = ($urandom_range(0, 3) == 0);
      if ((n / 200) % 2 == 1) rdy = ($urandom_range(0, 3) != 0);
      rs  = ($urandom_range(0, 249) == 0);
      stall_now = (w && a[IO_BIT] && mq.size() == DEPTH) ||
                  (FENCE && r && a[IO_BIT] && mq.size() != 0);
      step(w, r, a, d, rdy, rs);
      hold = stall_now && !rs;
    end

    // drain and confirm nothing was lost
    repeat (DEPTH + 2) step(0, 0, 32'h0, 32'h0, 1, 0);
    chk("scoreboard_left", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
